tagdv_ctrl: RTL and testbench
=============================

Name: tagdv_ctrl

Overview:
- Controller for a 2-way cache tag/dirty/valid store built from two simple dual-port tag-DV RAMs, one per way.
- Each RAM has one write port and one read port with a registered read address, so read data appears 1 cycle after the address.
- The controller does three jobs:
  - sequences lookups and returns hit, dirty and victim information;
  - arbitrates the shared write path between update requests (refill, store dirty-set, invalidate) and a clear sweep;
  - clears every entry after reset and on a flush request.
- Sits between the D/I-cache FSM and the tag-DV memories.

Parameters:
- TAG_WIDTH, 20, tag bits per entry.
- INDEX_WIDTH, 8, index bits; depth = 2**INDEX_WIDTH.
- Entry format (derived, ENTRY_WIDTH = TAG_WIDTH+2): {tag, dirty, valid}, valid is bit 0.

Ports:
- clk  in  1  clock, all state on rising edge
- rstn  in  1  asynchronous active-low reset
- lk_valid  in  1  lookup request
- lk_ready  out  1  lookup accepted when lk_valid&lk_ready
- lk_index  in  INDEX_WIDTH  lookup index
- lk_tag  in  TAG_WIDTH  lookup tag
- res_valid  out  1  lookup result valid (1-cycle pulse)
- res_hit  out  1  any way hit
- res_hit_way  out  1  hitting way
- res_hit_dirty  out  1  dirty bit of hitting way
- res_victim_way  out  1  way chosen for replacement
- res_victim_valid  out  1  victim entry valid
- res_victim_dirty  out  1  victim entry dirty (needs writeback)
- res_victim_tag  out  TAG_WIDTH  victim tag
- upd_valid  in  1  entry write request
- upd_ready  out  1  write accepted when upd_valid&upd_ready
- upd_way  in  1  target way
- upd_index  in  INDEX_WIDTH  target index
- upd_tag, upd_dirty, upd_vbit  in  TAG_WIDTH,1,1  entry contents
- flush_req  in  1  start a clear sweep (level sampled in IDLE)
- busy  out  1  sweep in progress
- mem_addra  out  INDEX_WIDTH  write address, shared by both ways
- mem_dina  out  ENTRY_WIDTH  write data, shared by both ways
- mem_wea  out  2  per-way write enable
- mem_addrb  out  INDEX_WIDTH  read address, shared
- mem_doutb0, mem_doutb1  in  ENTRY_WIDTH  way 0/1 read data, valid 1 cycle after mem_addrb

Behaviour:
- **States:** SWEEP, IDLE. rstn low drives SWEEP with sweep_idx=0. This holds even when reset arrives mid-sweep or mid-lookup: any in-flight result is dropped.
- **Reset values:**
  - busy=1; lk_ready=0, upd_ready=0;
  - res_* = 0; mem_wea=0, mem_addra=0, mem_dina=0, mem_addrb=0;
  - LFSR = 8'h01.
- **SWEEP:**
  - Each cycle: mem_wea=2'b11, mem_addra=sweep_idx, mem_dina=0; sweep_idx increments.
  - After index 2**INDEX_WIDTH-1 is written, go to IDLE next cycle. Full sweep = 2**INDEX_WIDTH cycles of busy.
  - lk_ready=upd_ready=0 throughout. flush_req is ignored.
- **IDLE entry conditions:** lk_ready=1 and upd_ready=1. If flush_req=1 in IDLE, go to SWEEP next cycle with sweep_idx=0. In that cycle, lookups and updates presented alongside flush_req are still accepted.
- **Lookup:**
  - mem_addrb = lk_index combinationally.
  - On accept, register lk_tag/lk_index; res_valid=1 the following cycle. Throughput 1/cycle, no stalls.
  - Hit in way w = entry_w.valid && entry_w.tag==registered tag. If both ways hit, way 0 wins.
  - res_hit_dirty = dirty bit of the winning way; 0 if no hit.
- **Victim selection:**
  - First invalid way, way 0 preferred.
  - Otherwise LFSR[0]. The LFSR is an 8-bit Fibonacci LFSR, taps 8,6,5,4, advanced on each accepted lookup.
  - res_victim_* report the chosen entry; they are valid on hit too, and the cache FSM ignores them in that case.
- **Update:**
  - On accept: mem_wea[upd_way]=1, mem_addra=upd_index, mem_dina={upd_tag,upd_dirty,upd_vbit}, same cycle.
  - Invalidate = upd_vbit=0.
- **Write/read collision forwarding:** if a write to way w at index X is issued in the same cycle a lookup of X is accepted, the result uses the written entry for way w instead of mem_doutb_w. A write issued in the result cycle is not reflected in that result.
- Outputs not driven by an active operation return to 0 (mem_wea, res_valid).

Optional Feature:
- Macro: TAGDV_CTRL_STAT_EN.
- **Defined:** adds outputs stat_hit_cnt and stat_miss_cnt, 32 bits each, wrapping.
  - Incremented on each res_valid with res_hit=1 or res_hit=0 respectively.
  - Cleared by rstn only; a sweep does not clear them.
- **Undefined:** the counters are absent and the ports are tied to 0.

Test Plan:
- Release rstn, hold lk_valid=1 -> busy=1 and lk_ready=0 for exactly 256 cycles; every index in both ways has mem_wea=11 and dina=0. Then busy=0 and lk_ready=1.
- Update way1 idx 0x3A tag 0x12345 dirty=1 vbit=1. Two cycles later look up 0x3A/0x12345 -> res_hit=1, res_hit_way=1, res_hit_dirty=1. Look up tag 0x12346 -> res_hit=0, victim_way=0, victim_valid=0.
- Fill both ways of idx 0x05 valid and dirty, then look up a miss -> victim_way=LFSR[0] (first lookup after reset gives 1), victim_dirty=1, victim_tag matches the stored entry.
- Same-cycle update way0 idx 0x10 tag 0xABCDE vbit=1 and lookup idx 0x10 tag 0xABCDE -> res_hit=1 way0 next cycle, regardless of RAM read-during-write behaviour.
- flush_req pulsed in IDLE together with an accepted lookup -> lookup result returned next cycle, then a 256-cycle sweep. Later lookup of the previously valid entry -> res_hit=0.
- Assert rstn low at sweep_idx=100 -> outputs return to reset values immediately; after release the sweep restarts at index 0 and busy lasts the full 256 cycles.
- With TAGDV_CTRL_STAT_EN: 3 hits + 2 misses -> stat_hit_cnt=3, stat_miss_cnt=2.

Source files
------------

// File: rtl/tagdv_ctrl_if.sv
// Lookup, result and update handshake bundle between the cache FSM (master)
// and the tag/dirty/valid store controller (slave).
interface tagdv_ctrl_if #(
    parameter int TAG_WIDTH   = 20,
    parameter int INDEX_WIDTH = 8
);
    logic                   lk_valid;
    logic                   lk_ready;
    logic [INDEX_WIDTH-1:0] lk_index;
    logic [TAG_WIDTH-1:0]   lk_tag;

    logic                   res_valid;
    logic                   res_hit;
    logic                   res_hit_way;
    logic                   res_hit_dirty;
    logic                   res_victim_way;
    logic                   res_victim_valid;
    logic                   res_victim_dirty;
    logic [TAG_WIDTH-1:0]   res_victim_tag;

    logic                   upd_valid;
    logic                   upd_ready;
    logic                   upd_way;
    logic [INDEX_WIDTH-1:0] upd_index;
    logic [TAG_WIDTH-1:0]   upd_tag;
    logic                   upd_dirty;
    logic                   upd_vbit;

    modport master (
        output lk_valid, lk_index, lk_tag,
        output upd_valid, upd_way, upd_index, upd_tag, upd_dirty, upd_vbit,
        input  lk_ready, upd_ready,
        input  res_valid, res_hit, res_hit_way, res_hit_dirty,
        input  res_victim_way, res_victim_valid, res_victim_dirty, res_victim_tag
    );

    modport slave (
        input  lk_valid, lk_index, lk_tag,
        input  upd_valid, upd_way, upd_index, upd_tag, upd_dirty, upd_vbit,
        output lk_ready, upd_ready,
        output res_valid, res_hit, res_hit_way, res_hit_dirty,
        output res_victim_way, res_victim_valid, res_victim_dirty, res_victim_tag
    );
endinterface

// File: rtl/tagdv_ctrl.sv
// 2-way tag/dirty/valid store controller: lookup pipeline, write arbitration, clear sweep.
// Optional hit/miss counters are built when TAGDV_CTRL_STAT_EN is defined.
module tagdv_ctrl #(
    parameter  int TAG_WIDTH   = 20,
    parameter  int INDEX_WIDTH = 8,
    localparam int ENTRY_WIDTH = TAG_WIDTH + 2
) (
    input  logic                   clk,
    input  logic                   rstn,
    tagdv_ctrl_if.slave            cif,
    input  logic                   flush_req,
    output logic                   busy,
    output logic [INDEX_WIDTH-1:0] mem_addra,
    output logic [ENTRY_WIDTH-1:0] mem_dina,
    output logic [1:0]             mem_wea,
    output logic [INDEX_WIDTH-1:0] mem_addrb,
    input  logic [ENTRY_WIDTH-1:0] mem_doutb0,
    input  logic [ENTRY_WIDTH-1:0] mem_doutb1,
    output logic [31:0]            stat_hit_cnt,
    output logic [31:0]            stat_miss_cnt
);
    typedef enum logic {SWEEP = 1'b0, IDLE = 1'b1} state_t;

    state_t                 state, state_nxt;
    logic [INDEX_WIDTH-1:0] sweep_idx, sweep_idx_nxt;
    logic [7:0]             lfsr;

    logic                   idle, lk_fire, upd_fire;
    logic [ENTRY_WIDTH-1:0] upd_entry;

    logic                   vld_p1;
    logic [TAG_WIDTH-1:0]   tag_p1;
    logic                   rnd_p1;
    logic [1:0]             fwd_p1;
    logic [ENTRY_WIDTH-1:0] fwd_entry_p1;

    logic [ENTRY_WIDTH-1:0] entry0, entry1;
    logic                   hit0, hit1, victim_way;
    logic [ENTRY_WIDTH-1:0] victim_entry;

    assign idle      = (state == IDLE);
    assign lk_fire   = cif.lk_valid && idle;
    assign upd_fire  = cif.upd_valid && idle;
    assign upd_entry = {cif.upd_tag, cif.upd_dirty, cif.upd_vbit};

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= SWEEP;
            sweep_idx <= '0;
        end else begin
            state     <= state_nxt;
            sweep_idx <= sweep_idx_nxt;
        end
    end

    // sweep_idx wraps to zero on its last write, so a new sweep always starts at 0
    always_comb begin
        state_nxt     = state;
        sweep_idx_nxt = '0;
        case (state)
            SWEEP: begin
                sweep_idx_nxt = sweep_idx + INDEX_WIDTH'(1);
                if (&sweep_idx) state_nxt = IDLE;
            end
            IDLE: begin
                if (flush_req) state_nxt = SWEEP;
            end
            default: state_nxt = SWEEP;
        endcase
    end

    // ---- stage p0 -> p1: accept lookup, capture tag, victim coin and forwarding ----
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vld_p1 <= 1'b0;
            lfsr   <= 8'h01;
        end else begin
            vld_p1 <= lk_fire;
            if (lk_fire) lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        end
    end

    always_ff @(posedge clk) begin
        if (lk_fire) begin
            tag_p1       <= cif.lk_tag;
            rnd_p1       <= lfsr[0];
            fwd_p1       <= (upd_fire && cif.upd_index == cif.lk_index) ?
                            {cif.upd_way, ~cif.upd_way} : 2'b00;
            fwd_entry_p1 <= upd_entry;
        end
    end

    // ---- stage p1: RAM data (or forwarded write) resolved into hit and victim ----
    assign entry0       = fwd_p1[0] ? fwd_entry_p1 : mem_doutb0;
    assign entry1       = fwd_p1[1] ? fwd_entry_p1 : mem_doutb1;
    assign hit0         = entry0[0] && (entry0[ENTRY_WIDTH-1:2] == tag_p1);
    assign hit1         = entry1[0] && (entry1[ENTRY_WIDTH-1:2] == tag_p1);
    assign victim_way   = !entry0[0] ? 1'b0 : (!entry1[0] ? 1'b1 : rnd_p1);
    assign victim_entry = victim_way ? entry1 : entry0;

    always_comb begin
        busy                 = 1'b0;
        cif.lk_ready         = 1'b0;
        cif.upd_ready        = 1'b0;
        mem_wea              = 2'b00;
        mem_addra            = '0;
        mem_dina             = '0;
        mem_addrb            = '0;
        cif.res_valid        = 1'b0;
        cif.res_hit          = 1'b0;
        cif.res_hit_way      = 1'b0;
        cif.res_hit_dirty    = 1'b0;
        cif.res_victim_way   = 1'b0;
        cif.res_victim_valid = 1'b0;
        cif.res_victim_dirty = 1'b0;
        cif.res_victim_tag   = '0;
        case (state)
            SWEEP: begin
                busy = 1'b1;
                // no RAM writes while reset is held
                if (rstn) begin
                    mem_wea   = 2'b11;
                    mem_addra = sweep_idx;
                end
            end
            IDLE: begin
                cif.lk_ready  = 1'b1;
                cif.upd_ready = 1'b1;
                mem_addrb     = cif.lk_index;
                if (upd_fire) begin
                    mem_wea   = {cif.upd_way, ~cif.upd_way};
                    mem_addra = cif.upd_index;
                    mem_dina  = upd_entry;
                end
            end
            default: ;
        endcase
        if (vld_p1) begin
            cif.res_valid        = 1'b1;
            cif.res_hit          = hit0 | hit1;
            cif.res_hit_way      = !hit0 && hit1;
            cif.res_hit_dirty    = hit0 ? entry0[1] : (hit1 ? entry1[1] : 1'b0);
            cif.res_victim_way   = victim_way;
            cif.res_victim_valid = victim_entry[0];
            cif.res_victim_dirty = victim_entry[1];
            cif.res_victim_tag   = victim_entry[ENTRY_WIDTH-1:2];
        end
    end

`ifdef TAGDV_CTRL_STAT_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stat_hit_cnt  <= '0;
            stat_miss_cnt <= '0;
        end else if (vld_p1) begin
            if (hit0 | hit1) stat_hit_cnt  <= stat_hit_cnt + 32'd1;
            else             stat_miss_cnt <= stat_miss_cnt + 32'd1;
        end
    end
`else
    assign stat_hit_cnt  = '0;
    assign stat_miss_cnt = '0;
`endif
endmodule

// File: tb/tb_tagdv_ctrl.sv
// Randomized and directed bench for tagdv_ctrl against a transaction-level cache model.
module tb_tagdv_ctrl;
    localparam int TW = 20;
    localparam int IW = 8;
    localparam int EW = TW + 2;
    localparam int DEPTH = 256;

    logic clk = 1'b0;
    logic rstn = 1'b1;
    always #5 clk = ~clk;

    tagdv_ctrl_if #(.TAG_WIDTH(TW), .INDEX_WIDTH(IW)) cif ();

    logic          flush_req;
    logic          busy;
    logic [IW-1:0] mem_addra, mem_addrb;
    logic [EW-1:0] mem_dina, mem_doutb0, mem_doutb1;
    logic [1:0]    mem_wea;
    logic [31:0]   stat_hit_cnt, stat_miss_cnt;

    tagdv_ctrl #(.TAG_WIDTH(TW), .INDEX_WIDTH(IW)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .cif          (cif),
        .flush_req    (flush_req),
        .busy         (busy),
        .mem_addra    (mem_addra),
        .mem_dina     (mem_dina),
        .mem_wea      (mem_wea),
        .mem_addrb    (mem_addrb),
        .mem_doutb0   (mem_doutb0),
        .mem_doutb1   (mem_doutb1),
        .stat_hit_cnt (stat_hit_cnt),
        .stat_miss_cnt(stat_miss_cnt)
    );

    // read-first RAMs so same-cycle write/read collisions depend on forwarding
    logic [EW-1:0] ram0 [DEPTH];
    logic [EW-1:0] ram1 [DEPTH];
    always @(posedge clk) begin
        mem_doutb0 <= ram0[mem_addrb];
        mem_doutb1 <= ram1[mem_addrb];
        if (mem_wea[0]) ram0[mem_addra] <= mem_dina;
        if (mem_wea[1]) ram1[mem_addra] <= mem_dina;
    end

    // cache contents as the FSM sees them
    bit          mv [2][DEPTH];
    bit          md [2][DEPTH];
    logic [TW-1:0] mt [2][DEPTH];
    int          sweep_left, sweep_pos;
    logic [7:0]  m_lfsr;
    bit          pend;
    bit          e_hit, e_hway, e_hdirty, e_vway, e_vvalid, e_vdirty;
    logic [TW-1:0] e_vtag;
    int          n_hit, n_miss;
    int          n_cmp = 0;
    int          n_err = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [7:0] lfsr_step(input logic [7:0] x);
        return {x[6:0], ^(x & 8'hB8)};
    endfunction

    function automatic void model_clear();
        for (int w = 0; w < 2; w++)
            for (int i = 0; i < DEPTH; i++) begin
                mv[w][i] = 1'b0;
                md[w][i] = 1'b0;
                mt[w][i] = '0;
            end
    endfunction

    task automatic tick();
        bit rdy;
        int i, vw;
        bit h0, h1;
        @(negedge clk);
        rdy = (sweep_left == 0);
        chk("busy", busy, !rdy);
        chk("lk_ready", cif.lk_ready, rdy);
        chk("upd_ready", cif.upd_ready, rdy);
        if (!rdy) begin
            chk("sweep_wea", mem_wea, 3);
            chk("sweep_addra", mem_addra, sweep_pos);
            chk("sweep_dina", mem_dina, 0);
        end else begin
            chk("addrb", mem_addrb, cif.lk_index);
            if (cif.upd_valid) begin
                chk("upd_wea", mem_wea, cif.upd_way ? 2 : 1);
                chk("upd_addra", mem_addra, cif.upd_index);
                chk("upd_dina", mem_dina, {cif.upd_tag, cif.upd_dirty, cif.upd_vbit});
            end else begin
                chk("idle_wea", mem_wea, 0);
            end
        end
        chk("res_valid", cif.res_valid, pend);
        if (pend) begin
            chk("res_hit", cif.res_hit, e_hit);
            chk("res_hit_way", cif.res_hit_way, e_hway);
            chk("res_hit_dirty", cif.res_hit_dirty, e_hdirty);
            chk("res_victim_way", cif.res_victim_way, e_vway);
            chk("res_victim_valid", cif.res_victim_valid, e_vvalid);
            chk("res_victim_dirty", cif.res_victim_dirty, e_vdirty);
            chk("res_victim_tag", cif.res_victim_tag, e_vtag);
            if (e_hit) n_hit++; else n_miss++;
        end
        pend = 1'b0;
        if (rdy && cif.upd_valid) begin
            mv[cif.upd_way][cif.upd_index] = cif.upd_vbit;
            md[cif.upd_way][cif.upd_index] = cif.upd_dirty;
            mt[cif.upd_way][cif.upd_index] = cif.upd_tag;
        end
        if (rdy && cif.lk_valid) begin
            i  = int'(cif.lk_index);
            h0 = mv[0][i] && mt[0][i] == cif.lk_tag;
            h1 = mv[1][i] && mt[1][i] == cif.lk_tag;
            e_hit    = h0 || h1;
            e_hway   = !h0 && h1;
            e_hdirty = h0 ? md[0][i] : (h1 ? md[1][i] : 1'b0);
            vw       = !mv[0][i] ? 0 : (!mv[1][i] ? 1 : int'(m_lfsr[0]));
            e_vway   = (vw == 1);
            e_vvalid = mv[vw][i];
            e_vdirty = md[vw][i];
            e_vtag   = mt[vw][i];
            pend     = 1'b1;
            m_lfsr   = lfsr_step(m_lfsr);
        end
        if (rdy && flush_req) begin
            model_clear();
            sweep_left = DEPTH;
            sweep_pos  = 0;
        end else if (!rdy) begin
            sweep_pos++;
            sweep_left--;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        cif.lk_valid  = 1'b0;
        cif.upd_valid = 1'b0;
        flush_req     = 1'b0;
    endtask

    task automatic set_lk(input logic [IW-1:0] idx, input logic [TW-1:0] tag);
        cif.lk_valid = 1'b1;
        cif.lk_index = idx;
        cif.lk_tag   = tag;
    endtask

    task automatic set_upd(input bit way, input logic [IW-1:0] idx, input logic [TW-1:0] tag,
                           input bit d, input bit v);
        cif.upd_valid = 1'b1;
        cif.upd_way   = way;
        cif.upd_index = idx;
        cif.upd_tag   = tag;
        cif.upd_dirty = d;
        cif.upd_vbit  = v;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        #2;
        chk("rst_busy", busy, 1);
        chk("rst_lk_ready", cif.lk_ready, 0);
        chk("rst_upd_ready", cif.upd_ready, 0);
        chk("rst_res_valid", cif.res_valid, 0);
        chk("rst_res_hit", cif.res_hit, 0);
        chk("rst_victim_tag", cif.res_victim_tag, 0);
        chk("rst_wea", mem_wea, 0);
        chk("rst_addra", mem_addra, 0);
        chk("rst_dina", mem_dina, 0);
        chk("rst_addrb", mem_addrb, 0);
        chk("rst_stat_hit", stat_hit_cnt, 0);
        chk("rst_stat_miss", stat_miss_cnt, 0);
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        model_clear();
        sweep_left = DEPTH;
        sweep_pos  = 0;
        pend       = 1'b0;
        m_lfsr     = 8'h01;
        n_hit      = 0;
        n_miss     = 0;
    endtask

    initial begin
        quiet();
        cif.lk_index  = '0;
        cif.lk_tag    = '0;
        cif.upd_way   = 1'b0;
        cif.upd_index = '0;
        cif.upd_tag   = '0;
        cif.upd_dirty = 1'b0;
        cif.upd_vbit  = 1'b0;
        @(posedge clk);
        #1;
        do_reset();

        // power-up sweep with a lookup held pending the whole time
        set_lk(8'h3A, 20'h0);
        repeat (DEPTH + 1) tick();
        quiet();

        // refill, hit, miss into an empty way
        set_upd(1'b1, 8'h3A, 20'h12345, 1'b1, 1'b1); tick(); quiet();
        tick();
        set_lk(8'h3A, 20'h12345); tick();
        set_lk(8'h3A, 20'h12346); tick(); quiet();
        tick();

        // both ways valid and dirty: victim comes from the LFSR
        set_upd(1'b0, 8'h05, 20'h11111, 1'b1, 1'b1); tick();
        set_upd(1'b1, 8'h05, 20'h22222, 1'b1, 1'b1); tick(); quiet();
        set_lk(8'h05, 20'h33333); tick();
        set_lk(8'h05, 20'h44444); tick(); quiet();
        tick();

        // write/lookup collision on the same index
        set_upd(1'b0, 8'h10, 20'hABCDE, 1'b0, 1'b1);
        set_lk(8'h10, 20'hABCDE); tick(); quiet();
        tick();

        // invalidate then look up
        set_upd(1'b1, 8'h05, 20'h22222, 1'b0, 1'b0); tick(); quiet();
        set_lk(8'h05, 20'h22222); tick(); quiet();
        tick();

        // flush alongside an accepted lookup, then check the entry is gone
        flush_req = 1'b1;
        set_lk(8'h3A, 20'h12345); tick(); quiet();
        repeat (DEPTH) tick();
        set_lk(8'h3A, 20'h12345); tick(); quiet();
        tick();

        // randomized traffic with occasional flushes
        for (int n = 0; n < 1500; n++) begin
            cif.lk_valid  = ($urandom_range(0, 3) != 0);
            cif.lk_index  = IW'($urandom_range(0, 7));
            cif.lk_tag    = 20'hA0000 + TW'($urandom_range(0, 3));
            cif.upd_valid = ($urandom_range(0, 2) == 0);
            cif.upd_way   = 1'($urandom_range(0, 1));
            cif.upd_index = IW'($urandom_range(0, 7));
            cif.upd_tag   = 20'hA0000 + TW'($urandom_range(0, 3));
            cif.upd_dirty = 1'($urandom_range(0, 1));
            cif.upd_vbit  = ($urandom_range(0, 4) != 0);
            flush_req     = ($urandom_range(0, 299) == 0);
            tick();
        end
        quiet();
        for (int n = 0; n < DEPTH + 2 && sweep_left != 0; n++) tick();

        // reset in the middle of a sweep restarts it from index 0
        flush_req = 1'b1; tick(); quiet();
        repeat (100) tick();
        chk("mid_sweep_pos", sweep_pos, 100);
        do_reset();
        repeat (DEPTH) tick();
        tick();

        // three hits and two misses for the statistics counters
        set_upd(1'b0, 8'h20, 20'h00AAA, 1'b0, 1'b1); tick();
        set_upd(1'b1, 8'h21, 20'h00BBB, 1'b1, 1'b1); tick(); quiet();
        set_lk(8'h20, 20'h00AAA); tick();
        set_lk(8'h21, 20'h00BBB); tick();
        set_lk(8'h20, 20'h00AAA); tick();
        set_lk(8'h21, 20'h00AAA); tick();
        set_lk(8'h22, 20'h00BBB); tick(); quiet();
        repeat (2) tick();
        chk("model_hits", n_hit, 3);
        chk("model_misses", n_miss, 2);
`ifdef TAGDV_CTRL_STAT_EN
        chk("stat_hit_cnt", stat_hit_cnt, 3);
        chk("stat_miss_cnt", stat_miss_cnt, 2);
`else
        chk("stat_hit_cnt", stat_hit_cnt, 0);
        chk("stat_miss_cnt", stat_miss_cnt, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
